addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder-subtractor; next generation of the team's 32-bit combinational adder-subtractor.
- Splits the operand width into STAGES equal chunks; one chunk is resolved per pipeline stage, and carry is registered between stages.
- Adds a valid/ready handshake with backpressure, plus carry, signed-overflow and zero flags.
- Sits between an operand producer and a result consumer in datapath experiments.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STAGES, 4, pipeline depth and chunk count; WIDTH % STAGES must be 0, and STAGES >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = a+b, 1 = a-b.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- carry_out  output  1  carry out of the MSB (for sub: 1 = no borrow).
- overflow  output  1  signed overflow.
- zero  output  1  pre-saturation sum == 0.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values: all stage valid bits = 0; out_valid = 0; sum = 0; carry_out = 0; overflow = 0; zero = 0. in_ready = 1 in the cycle after reset deasserts.
- Reset mid-operation: flushes every in-flight beat. No partial result is ever presented.
- Arithmetic: b' = sub ? ~b : b; carry-in = sub; result = a + b' + sub, modulo 2^WIDTH. CW = WIDTH/STAGES.
- Stage 0: computes chunk 0 (bits CW-1:0) from the input ports and registers that chunk, its carry, and the upper unprocessed a/b'/sub bits.
- Stage k (k >= 1): adds chunk k of the delayed a/b' using stage k-1's registered carry, and forwards the already-resolved lower result bits.
- Last stage flags:
  - carry_out = carry out of bit WIDTH-1.
  - overflow = (a[MSB] == b'[MSB]) && (raw_sum[MSB] != a[MSB]).
  - zero = (raw_sum == 0).
- Outputs: registered outputs of stage STAGES-1; out_valid = valid bit of the last stage.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Stage enable: en_last = !v_last || out_ready; en_k = !v_k || en_{k+1}; in_ready = en_0. Bubbles collapse.
  - When a stage is enabled, its valid bit loads the upstream valid bit (in_valid for stage 0).
  - Data registers of a disabled stage hold their value.
- Latency: a beat accepted on edge N presents out_valid = 1 after edge N+STAGES-1 when unstalled. Throughput is 1 beat/cycle.
- Stall: with out_ready = 0, the pipeline fills. After STAGES beats are held, in_ready = 0.
- Simultaneous accept and release on a full pipeline: allowed. in_ready = 1 when out_ready = 1, even with every stage full.
- Ordering: results leave in acceptance order; no beat is dropped or duplicated.
- Output stability: sum and all flags stay constant while out_valid && !out_ready.
- STAGES = 1: degenerates to a single registered adder with handshake.

Optional Feature:
- Macro: ADDSUB_PIPE_SATURATE_EN.
- Defined: in the last stage, if overflow = 1, sum = a[MSB] ? {1'b1, {WIDTH-1{1'b0}}} : {1'b0, {WIDTH-1{1'b1}}} (signed saturation).
  - overflow, carry_out and zero still report raw-sum values.
  - Latency is unchanged.
- Undefined: sum = raw wrapped result; no saturation logic is instantiated.

Test Plan (WIDTH=32, STAGES=4):
1. Hold reset for 2 cycles, then release -> out_valid=0, sum=0, all flags 0; in_ready=1 on the first cycle after release.
2. a=0xFFFF_FFFF, b=1, sub=0, accepted on edge N, out_ready=1 -> out_valid after edge N+3; sum=0x0000_0000, carry_out=1, zero=1, overflow=0.
3. a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, carry_out=0, overflow=0, zero=0. Then a=7, b=5, sub=1 -> sum=2, carry_out=1.
4. a=0x7FFF_FFFF, b=1, sub=0 -> overflow=1; sum=0x8000_0000 without the macro, 0x7FFF_FFFF with ADDSUB_PIPE_SATURATE_EN. a=0x8000_0000, b=1, sub=1 -> overflow=1; sum=0x7FFF_FFFF without the macro, 0x8000_0000 with it.
5. Ten back-to-back random beats with in_valid=1; out_ready=0 from the 2nd cycle for 8 cycles, then 1 -> in_ready=0 once 4 beats are held. All 10 results match a golden model, in order, with none lost; sum is stable during the stall.
6. Accept 3 beats, assert reset for 1 cycle mid-stream, then send a=1, b=2, sub=0 -> no pre-reset result emerges; the first out_valid carries sum=3.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: one WIDTH/STAGES chunk per stage, registered carries,
// valid/ready handshake with collapsing bubbles. Define ADDSUB_PIPE_SATURATE_EN for signed saturation.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = WIDTH / STAGES;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // Stage k sees only the operand bits from chunk k upward and the k*CW resolved result bits.
    localparam int AW = WIDTH - k * CW;
    localparam int RW = (k + 1) * CW;

    logic          v_q;
    logic          en;
    logic          ld;
    logic          vin_s;
    logic          cin_s;
    logic [AW-1:0] a_s;
    logic [AW-1:0] bp_s;
    logic [CW:0]   csum;
    logic [RW-1:0] res_d;

    always_comb begin
      csum = {1'b0, a_s[CW-1:0]} + {1'b0, bp_s[CW-1:0]} + {{CW{1'b0}}, cin_s};
    end

    if (k == 0) begin : head
      always_comb begin
        vin_s = in_valid;
        a_s   = a;
        bp_s  = sub ? ~b : b;
        cin_s = sub;
        res_d = csum[CW-1:0];
      end
    end else begin : body
      always_comb begin
        vin_s = stg[k-1].v_q;
        a_s   = stg[k-1].fwd.a_q;
        bp_s  = stg[k-1].fwd.bp_q;
        cin_s = stg[k-1].fwd.c_q;
        res_d = {csum[CW-1:0], stg[k-1].fwd.res_q};
      end
    end

    // Data only loads on a real beat so idle cycles never disturb the presented result.
    always_comb begin
      ld = en && vin_s;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
      end else if (en) begin
        v_q <= vin_s;
      end
    end

    if (k == STAGES - 1) begin : tail
      logic             c_q;
      logic             ovf_q;
      logic             zero_q;
      logic             ovf_d;
      logic             zero_d;
      logic [WIDTH-1:0] sum_q;
      logic [WIDTH-1:0] sum_d;

      always_comb begin
        en     = !v_q || out_ready;
        ovf_d  = (a_s[CW-1] == bp_s[CW-1]) && (res_d[WIDTH-1] != a_s[CW-1]);
        zero_d = (res_d == '0);
`ifdef ADDSUB_PIPE_SATURATE_EN
        if (ovf_d) begin
          sum_d = a_s[CW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
          sum_d = res_d;
        end
`else
        sum_d = res_d;
`endif
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          c_q    <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          sum_q  <= '0;
        end else if (ld) begin
          c_q    <= csum[CW];
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
          sum_q  <= sum_d;
        end
      end
    end else begin : fwd
      logic             c_q;
      logic [AW-CW-1:0] a_q;
      logic [AW-CW-1:0] bp_q;
      logic [RW-1:0]    res_q;

      always_comb begin
        en = !v_q || stg[k+1].en;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          c_q   <= 1'b0;
          a_q   <= '0;
          bp_q  <= '0;
          res_q <= '0;
        end else if (ld) begin
          c_q   <= csum[CW];
          a_q   <= a_s[AW-1:CW];
          bp_q  <= bp_s[AW-1:CW];
          res_q <= res_d;
        end
      end
    end
  end

  always_comb begin
    in_ready  = stg[0].en;
    out_valid = stg[STAGES-1].v_q;
    sum       = stg[STAGES-1].tail.sum_q;
    carry_out = stg[STAGES-1].tail.c_q;
    overflow  = stg[STAGES-1].tail.ovf_q;
    zero      = stg[STAGES-1].tail.zero_q;
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=32, STAGES=4): directed table, latency/stall/reset
// sequences and randomized traffic against an arithmetic reference model with an in-order scoreboard.
module tb_addsub_pipe;

  localparam int W = 32;
  localparam int S = 4;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  res_t q[$];

  // Reference: exact signed/unsigned arithmetic, then range tests for the flags.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    res_t        r;
    longint      sx;
    longint      sy;
    longint      t;
    logic [32:0] u;
    sx = $signed(x);
    sy = $signed(y);
    t  = s ? sx - sy : sx + sy;
    u  = {1'b0, x} + {1'b0, y};
    r.sum = t[31:0];
    r.c   = s ? (x >= y) : u[32];
    r.o   = (t > SMAX) || (t < SMIN);
    r.z   = (r.sum == 32'h0);
`ifdef ADDSUB_PIPE_SATURATE_EN
    if (r.o) r.sum = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: everything sampled at the falling edge, transfers happen on the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      check("in_ready", {31'b0, in_ready}, {31'b0, !((q.size() >= S) && !out_ready)});
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          check("sb_sum", sum, q[0].sum);
          if (out_ready) begin
            check("sb_carry", {31'b0, carry_out}, {31'b0, q[0].c});
            check("sb_overflow", {31'b0, overflow}, {31'b0, q[0].o});
            check("sb_zero", {31'b0, zero}, {31'b0, q[0].z});
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s);
    int   guard;
    logic took;
    a = x; b = y; sub = s; in_valid = 1'b1;
    took = 1'b0;
    guard = 0;
    while (!took && guard < 200) begin
      @(negedge clk);
      took = in_ready;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    if (!took) check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 100) begin
      tick();
      g++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   g;
    tbl[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h5, 32'h7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{32'h7, 32'h5, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
`ifdef ADDSUB_PIPE_SATURATE_EN
    tbl[3] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
    tbl[3] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
`endif
    tbl[5] = '{32'h0, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_carry", {31'b0, carry_out}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();

    // Directed vectors, each with exact latency: out_valid only after the third edge past acceptance.
    for (int i = 0; i < 6; i++) begin
      a = tbl[i].a; b = tbl[i].b; sub = tbl[i].sub; in_valid = 1'b1;
      @(negedge clk);
      check("tbl_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < S; k++) begin
        @(negedge clk);
        check("tbl_latency_valid", {31'b0, out_valid}, {31'b0, (k == S - 1)});
      end
      check("tbl_sum", sum, tbl[i].sum);
      check("tbl_carry", {31'b0, carry_out}, {31'b0, tbl[i].c});
      check("tbl_overflow", {31'b0, overflow}, {31'b0, tbl[i].o});
      check("tbl_zero", {31'b0, zero}, {31'b0, tbl[i].z});
      tick();
    end
    drain();

    // Ten back-to-back beats with an 8-cycle output stall starting in the second cycle.
    fork
      begin
        for (int i = 0; i < 10; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      begin
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (8) tick();
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight: none of them may appear afterwards.
    send(32'h11, 32'h22, 1'b0);
    send(32'h33, 32'h44, 1'b1);
    send(32'h55, 32'h66, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send(32'h1, 32'h2, 1'b0);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!out_valid && g < 20);
    check("post_reset_valid", {31'b0, out_valid}, 32'd1);
    check("post_reset_sum", sum, 32'd3);
    tick();
    drain();

    // Random traffic: random gaps, random backpressure, corner-biased operands.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          send(pick(), pick(), 1'($urandom_range(0, 1)));
        end
      end
      begin
        repeat (150) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
